// File: rtl/sort_job_dispatch_pkg.sv
// sort_dispatch_pkg: shared defaults, descriptor layout and hold window for the sort job dispatcher.
package sort_dispatch_pkg;
    localparam int ENGINE_NUM_DEF = 4;
    localparam int DATA_WIDTH_DEF = 1024;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int CNT_WIDTH_DEF  = 32;
    localparam int HOLD_CYCLES    = 2;
    localparam int PASID_OFS      = 0;
    localparam int BEAT_NUM_OFS   = 32;
    localparam int SRC_ADDR_OFS   = 64;
    localparam int DST_ADDR_OFS   = 128;

    typedef struct packed {
        logic [63:0] dst_addr;
        logic [63:0] src_addr;
        logic [31:0] beat_num;
        logic [31:0] pasid;
    } sort_desc_hdr_t;

    function automatic sort_desc_hdr_t desc_hdr(input logic [DST_ADDR_OFS+63:0] d);
        return sort_desc_hdr_t'(d);
    endfunction
endpackage

// File: rtl/sort_job_dispatch_if.sv
// sort_job_dispatch_if: job handshake, per-core start/ready and status signals of the dispatcher.
interface sort_job_dispatch_if #(
    parameter int ENGINE_NUM = sort_dispatch_pkg::ENGINE_NUM_DEF,
    parameter int DATA_WIDTH = sort_dispatch_pkg::DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = sort_dispatch_pkg::CNT_WIDTH_DEF
);
    logic                  job_valid;
    logic                  job_ready;
    logic [DATA_WIDTH-1:0] job_data;
    logic [ENGINE_NUM-1:0] engine_ready;
    logic [ENGINE_NUM-1:0] engine_start;
    logic [DATA_WIDTH-1:0] engine_data;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  dispatch_cnt;
    logic [CNT_WIDTH-1:0]  stall_cnt;

    modport slave (
        input  job_valid, job_data, engine_ready,
        output job_ready, engine_start, engine_data, busy, dispatch_cnt, stall_cnt
    );
    modport master (
        output job_valid, job_data, engine_ready,
        input  job_ready, engine_start, engine_data, busy, dispatch_cnt, stall_cnt
    );
endinterface

// File: rtl/sort_job_dispatch_rr_arb.sv
// sort_rr_arb: combinational round-robin arbiter granting the first request at or above ptr_i, wrapping.
module sort_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 grant_valid_o
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] idx;

    // Walk downward so the candidate closest to ptr_i is assigned last and wins.
    always_comb begin
        grant_idx_o = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (req_i[idx]) grant_idx_o = idx;
        end
    end

    assign grant_valid_o = |req_i;
    assign grant_o       = grant_valid_o ? N'(1) << grant_idx_o : '0;
endmodule

// File: rtl/sort_job_dispatch.sv
// sort_job_dispatch: buffers sort descriptors and issues them round-robin to idle sort cores.
// Define SORT_DISPATCH_STAT_EN to build the stall-cycle counter behind stall_cnt.
module sort_job_dispatch
    import sort_dispatch_pkg::*;
#(
    parameter int ENGINE_NUM = ENGINE_NUM_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input logic                clk,
    input logic                rst,
    sort_job_dispatch_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = $clog2(ENGINE_NUM);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [DATA_WIDTH-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                 count_q, count_d;
    logic                          ready_q;
    logic [EW-1:0]                 rr_ptr_q, grant_idx;
    logic [ENGINE_NUM-1:0][HW-1:0] hold_q, hold_d;
    logic [ENGINE_NUM-1:0]         hold_mask, elig, grant, start_q;
    logic [DATA_WIDTH-1:0]         data_q;
    logic [CNT_WIDTH-1:0]          disp_q;
    logic                          push, pop, grant_valid;

    assign push    = bus.job_valid && ready_q;
    assign count_d = count_q + CW'(push) - CW'(pop);
    assign elig    = bus.engine_ready & ~hold_mask;

    sort_rr_arb #(.N(ENGINE_NUM)) u_arb (
        .req_i        (count_q != '0 ? elig : '0),
        .ptr_i        (rr_ptr_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx),
        .grant_valid_o(grant_valid)
    );

    assign pop = grant_valid;

    // A started core keeps engine_ready high for one more cycle, so mask it out meanwhile.
    always_comb begin
        hold_mask = '0;
        hold_d = hold_q;
        for (int i = 0; i < ENGINE_NUM; i++) begin
            hold_mask[i] = hold_q[i] != '0;
            hold_d[i] = grant[i] ? HW'(HOLD_CYCLES) : hold_q[i] - HW'(hold_mask[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            rr_ptr_q <= '0;
            hold_q   <= '0;
            start_q  <= '0;
            data_q   <= '0;
            disp_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
            ready_q  <= count_d != CW'(FIFO_DEPTH);
            rr_ptr_q <= pop ? (grant_idx == EW'(ENGINE_NUM - 1) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
            hold_q   <= hold_d;
            start_q  <= grant;
            data_q   <= pop ? mem_q[rd_ptr_q] : data_q;
            disp_q   <= disp_q + CNT_WIDTH'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.job_data;
    end

    assign bus.job_ready    = ready_q;
    assign bus.engine_start = start_q;
    assign bus.engine_data  = data_q;
    assign bus.busy         = count_q != '0 || |start_q;
    assign bus.dispatch_cnt = disp_q;

`ifdef SORT_DISPATCH_STAT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else if (count_q != '0 && elig == '0) stall_q <= stall_q + 1'b1;
    end

    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_sort_job_dispatch.sv
// tb_sort_job_dispatch: directed checks of queuing, round-robin dispatch, backpressure, reset and counter wrap.
module tb_sort_job_dispatch;
`ifdef SORT_DISPATCH_STAT_EN
    localparam int STAT_ON = 1;
`else
    localparam int STAT_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic auto_rdy;
    logic [3:0] man_rdy;
    logic [3:0] model_rdy = 4'hF;
    int tmr [4] = '{default: 0};
    int last_c [4] = '{default: -100};
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int s_starts = 0;
    int gidx_q [$];
    logic [1023:0] gdat_q [$];
    int exp_rr [6] = '{1, 2, 3, 0, 1, 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_job_dispatch_if #(.ENGINE_NUM(4), .DATA_WIDTH(1024), .CNT_WIDTH(32)) bus ();
    sort_job_dispatch_if #(.ENGINE_NUM(2), .DATA_WIDTH(8), .CNT_WIDTH(2)) s_bus ();

    sort_job_dispatch #(.ENGINE_NUM(4), .DATA_WIDTH(1024), .FIFO_DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    sort_job_dispatch #(.ENGINE_NUM(2), .DATA_WIDTH(8), .FIFO_DEPTH(2), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .bus(s_bus)
    );

    assign bus.engine_ready = auto_rdy ? model_rdy : man_rdy;

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1023:0] mk(input int k);
        return {32{32'hA5A50000 | 32'(k)}};
    endfunction

    // Core model: drops ready one cycle after its start, busy for three cycles.
    always @(negedge clk) begin
        if (|bus.engine_start) begin
            chk("onehot", 1024'($onehot(bus.engine_start)), 1);
            gdat_q.push_back(bus.engine_data);
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.engine_start[i]) begin
                chk($sformatf("hold_gap_e%0d", i), 1024'((cyc - last_c[i]) >= 3), 1);
                last_c[i] = cyc;
                gidx_q.push_back(i);
            end
            if (tmr[i] != 0) tmr[i]--;
            if (bus.engine_start[i]) tmr[i] = 4;
            model_rdy[i] = (tmr[i] == 0) || (tmr[i] == 4);
        end
    end

    always @(negedge clk) if (|s_bus.engine_start) s_starts++;

    task automatic push(input logic [1023:0] d);
        int t = 0;
        bus.job_valid = 1'b1;
        bus.job_data = d;
        while (!bus.job_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) chk("push_ready", 1024'(bus.job_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.job_valid = 1'b0;
    endtask

    task automatic wait_n(input string tag, input int n);
        for (int t = 0; t < 200 && gidx_q.size() < n; t++) @(negedge clk);
        chk(tag, 1024'(gidx_q.size()), 1024'(n));
    endtask

    task automatic clear_q();
        gidx_q.delete();
        gdat_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic acc;
        rst = 1'b1;
        auto_rdy = 1'b0;
        man_rdy = 4'h0;
        bus.job_valid = 1'b0;
        bus.job_data = '0;
        s_bus.job_valid = 1'b0;
        s_bus.job_data = '0;
        s_bus.engine_ready = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_job_ready", 1024'(bus.job_ready), 0);
        chk("rst_start", 1024'(bus.engine_start), 0);
        chk("rst_data", bus.engine_data, 0);
        chk("rst_busy", 1024'(bus.busy), 0);
        chk("rst_dispatch", 1024'(bus.dispatch_cnt), 0);
        chk("rst_stall", 1024'(bus.stall_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_job_ready", 1024'(bus.job_ready), 1);
        // single job: start two cycles after the handshake
        auto_rdy = 1'b1;
        clear_q();
        push(mk(1));
        chk("t1_no_start_c1", 1024'(bus.engine_start), 0);
        @(negedge clk);
        chk("t1_start", 1024'(bus.engine_start), 4'b0001);
        chk("t1_data", bus.engine_data, mk(1));
        chk("t1_dispatch", 1024'(bus.dispatch_cnt), 1);
        chk("t1_busy_c2", 1024'(bus.busy), 1);
        @(negedge clk);
        chk("t1_busy_c3", 1024'(bus.busy), 0);
        chk("t1_start_c3", 1024'(bus.engine_start), 0);
        repeat (6) @(negedge clk);
        // round-robin: pointer already advanced to 1 by the first job
        clear_q();
        for (int k = 0; k < 6; k++) push(mk(16 + k));
        wait_n("t2_count", 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_idx%0d", k), 1024'(gidx_q[k]), 1024'(exp_rr[k]));
            chk($sformatf("t2_data%0d", k), gdat_q[k], mk(16 + k));
        end
        chk("t2_dispatch", 1024'(bus.dispatch_cnt), 7);
        // backpressure from a fresh reset
        auto_rdy = 1'b0;
        man_rdy = 4'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t3_dispatch_clr", 1024'(bus.dispatch_cnt), 0);
        clear_q();
        for (int k = 0; k < 4; k++) push(mk(32 + k));
        chk("t3_full_ready", 1024'(bus.job_ready), 0);
        chk("t3_full_busy", 1024'(bus.busy), 1);
        chk("t3_stall3", 1024'(bus.stall_cnt), 1024'(3 * STAT_ON));
        bus.job_valid = 1'b1;
        bus.job_data = mk(36);
        repeat (2) @(negedge clk);
        chk("t3_full_ready2", 1024'(bus.job_ready), 0);
        chk("t3_stall5", 1024'(bus.stall_cnt), 1024'(5 * STAT_ON));
        man_rdy = 4'b0100;
        @(negedge clk);
        chk("t3_start", 1024'(bus.engine_start), 4'b0100);
        chk("t3_data", bus.engine_data, mk(32));
        chk("t3_ready_back", 1024'(bus.job_ready), 1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        wait_n("t3_count", 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_idx%0d", k), 1024'(gidx_q[k]), 2);
            chk($sformatf("t3_data%0d", k), gdat_q[k], mk(32 + k));
        end
        chk("t3_dispatch", 1024'(bus.dispatch_cnt), 5);
        // simultaneous push and pop at count 2
        man_rdy = 4'h0;
        clear_q();
        push(mk(48));
        push(mk(49));
        man_rdy = 4'b0001;
        push(mk(50));
        chk("t4_count", 1024'(dut.count_q), 2);
        chk("t4_start", 1024'(bus.engine_start), 4'b0001);
        chk("t4_data", bus.engine_data, mk(48));
        wait_n("t4_n", 3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4_idx%0d", k), 1024'(gidx_q[k]), 0);
            chk($sformatf("t4_data%0d", k), gdat_q[k], mk(48 + k));
        end
        chk("t4_dispatch", 1024'(bus.dispatch_cnt), 8);
        // reset mid-operation
        man_rdy = 4'h0;
        clear_q();
        for (int k = 0; k < 3; k++) push(mk(64 + k));
        man_rdy = 4'b0001;
        @(negedge clk);
        chk("t5_pre_start", 1024'(bus.engine_start), 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("t5_start", 1024'(bus.engine_start), 0);
        chk("t5_busy", 1024'(bus.busy), 0);
        chk("t5_dispatch", 1024'(bus.dispatch_cnt), 0);
        chk("t5_count", 1024'(dut.count_q), 0);
        chk("t5_job_ready", 1024'(bus.job_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        repeat (10) @(negedge clk);
        chk("t5_no_starts", 1024'(gidx_q.size()), 0);
        chk("t5_count_after", 1024'(dut.count_q), 0);
        // counter wrap on a 2-bit counter instance
        n = 0;
        s_bus.job_valid = 1'b1;
        for (int t = 0; t < 50 && n < 4; t++) begin
            s_bus.job_data = 8'(n);
            acc = s_bus.job_ready;
            @(negedge clk);
            if (acc) n++;
        end
        s_bus.job_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("t6_starts", 1024'(s_starts), 4);
        chk("t6_wrap", 1024'(s_bus.dispatch_cnt), 0);
        chk("t6_busy", 1024'(s_bus.busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
